// File: rtl/shift_add_mult_pkg.sv
// rtl/shift_add_mult_pkg.sv - shared types and sizing helpers for the shift-and-add multiplier
package shift_add_mult_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must reach n (one past the last iteration), never narrower than 1 bit.
    function automatic int cnt_width(input int iterations);
        int w;
        w = $clog2(iterations + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// rtl/shift_add_step.sv - one combinational add-then-shift iteration of the multiplier
module shift_add_step #(
    parameter int m = 8,
    parameter int n = 8
) (
    input  logic [m:0]   a,
    input  logic [m-1:0] dr,
    input  logic [n-1:0] qr,
    output logic [m:0]   a_next,
    output logic [n-1:0] qr_next
);

    logic [m:0] sum;

    // a[m] is always zero after a shift, so adding the whole register equals adding a[m-1:0].
    always_comb begin
        sum = a;
        if (qr[0]) begin
            sum = a + {1'b0, dr};
        end
        a_next = {1'b0, sum[m:1]};
    end

    generate
        if (n == 1) begin : g_qr_single
            assign qr_next = sum[0];
        end else begin : g_qr_multi
            assign qr_next = {sum[0], qr[n-1:1]};
        end
    endgenerate

endmodule

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - sequential unsigned m x n multiplier, reset release starts one product
module shift_add_multiplier
    import shift_add_mult_pkg::*;
#(
    parameter int m = 8,
    parameter int n = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [m-1:0]   D,
    input  logic [n-1:0]   Q,
    output logic [m+n-1:0] out
);

    localparam int CNT_W = cnt_width(n);

    state_t           state_q;
    state_t           state_d;
    logic [m:0]       a_q;
    logic [n-1:0]     qr_q;
    logic [m-1:0]     dr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [m:0]       a_nxt;
    logic [n-1:0]     qr_nxt;
    logic             load_ops;
    logic             do_step;
    logic             last_step;

    shift_add_step #(
        .m(m),
        .n(n)
    ) u_step (
        .a      (a_q),
        .dr     (dr_q),
        .qr     (qr_q),
        .a_next (a_nxt),
        .qr_next(qr_nxt)
    );

    assign last_step = (cnt_q == CNT_W'(n - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_ops = 1'b0;
        do_step  = 1'b0;
        case (state_q)
            LOAD: begin
                load_ops = 1'b1;
                state_d  = CALC;
            end
            CALC: begin
                do_step = 1'b1;
                if (last_step) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // Operands are captured only in LOAD; DONE holds everything until the next reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            qr_q  <= '0;
            dr_q  <= '0;
            cnt_q <= '0;
            out   <= '0;
        end else if (load_ops) begin
            dr_q  <= D;
            qr_q  <= Q;
            a_q   <= '0;
            cnt_q <= '0;
        end else if (do_step) begin
            a_q   <= a_nxt;
            qr_q  <= qr_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last_step) begin
                out <= {a_nxt[m-1:0], qr_nxt};
            end
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - self-checking bench for shift_add_multiplier (8x8 and 5x11)
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a;
    logic [7:0]  d_a;
    logic [7:0]  q_a;
    logic [15:0] out_a;

    logic        rst_b;
    logic [4:0]  d_b;
    logic [10:0] q_b;
    logic [15:0] out_b;

    int n_cmp = 0;
    int n_bad = 0;

    shift_add_multiplier #(.m(8), .n(8)) dut_a (
        .clk(clk), .rst(rst_a), .D(d_a), .Q(q_a), .out(out_a)
    );

    shift_add_multiplier #(.m(5), .n(11)) dut_b (
        .clk(clk), .rst(rst_b), .D(d_b), .Q(q_b), .out(out_b)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start_a(input logic [7:0] d, input logic [7:0] q);
        @(negedge clk);
        rst_a = 1'b0;
        d_a   = d;
        q_a   = q;
        @(negedge clk);
        rst_a = 1'b1;
    endtask

    // Product is expected on edge 9 after release and from then on; zero before that.
    task automatic track_a(input logic [7:0] d, input logic [7:0] q,
                           input int first, input int last, input string tag);
        logic [15:0] prod;
        prod = {8'd0, d} * {8'd0, q};
        for (int e = first; e <= last; e++) begin
            @(posedge clk);
            #1;
            check(tag, out_a, (e >= 9) ? prod : 16'd0);
        end
    endtask

    task automatic run_b(input logic [4:0] d, input logic [10:0] q, input string tag);
        logic [15:0] prod;
        prod = {11'd0, d} * {5'd0, q};
        @(negedge clk);
        rst_b = 1'b0;
        d_b   = d;
        q_b   = q;
        @(negedge clk);
        rst_b = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            @(posedge clk);
            #1;
            check(tag, out_b, (e >= 12) ? prod : 16'd0);
        end
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rq;

        rst_a = 1'b1;
        rst_b = 1'b1;
        d_a   = 8'hFF;
        q_a   = 8'hFF;
        d_b   = '0;
        q_b   = '0;
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("reset_a", out_a, 16'd0);
        check("reset_b", out_b, 16'd0);

        @(negedge clk);
        rst_a = 1'b1;
        track_a(8'hFF, 8'hFF, 1, 10, "ff_x_ff");

        // Asynchronous clear: out drops without waiting for an edge.
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("async_clear", out_a, 16'd0);
        d_a = 8'h0F;
        q_a = 8'h87;
        @(negedge clk);
        rst_a = 1'b1;
        track_a(8'h0F, 8'h87, 1, 9, "0f_x_87");

        start_a(8'h00, 8'hAB);
        track_a(8'h00, 8'hAB, 1, 9, "zero_d");
        start_a(8'h5A, 8'h00);
        track_a(8'h5A, 8'h00, 1, 9, "zero_q");
        start_a(8'h01, 8'hC3);
        track_a(8'h01, 8'hC3, 1, 9, "identity");

        start_a(8'h12, 8'h34);
        track_a(8'h12, 8'h34, 1, 3, "chg_early");
        @(negedge clk);
        d_a = 8'($urandom);
        q_a = 8'($urandom);
        track_a(8'h12, 8'h34, 4, 9, "chg_calc");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            d_a = 8'($urandom);
            q_a = 8'($urandom);
            @(posedge clk);
            #1;
            check("chg_done", out_a, 16'h03A8);
        end

        rd = 8'($urandom);
        rq = 8'($urandom);
        start_a(rd, rq);
        track_a(rd, rq, 1, 4, "abort_pre");
        #2;
        rst_a = 1'b0;
        #1;
        check("abort_clear", out_a, 16'd0);
        d_a = 8'h07;
        q_a = 8'h09;
        @(posedge clk);
        #1;
        check("abort_held", out_a, 16'd0);
        @(negedge clk);
        rst_a = 1'b1;
        track_a(8'h07, 8'h09, 1, 9, "abort_restart");

        for (int i = 0; i < 500; i++) begin
            rd = 8'($urandom);
            rq = 8'($urandom);
            start_a(rd, rq);
            track_a(rd, rq, 1, 9, "rand_8x8");
        end

        run_b(5'h1F, 11'h7FF, "max_5x11");
        run_b(5'h00, 11'h5A5, "zero_5x11");
        for (int i = 0; i < 40; i++) begin
            run_b(5'($urandom), 11'($urandom), "rand_5x11");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
